// File: rtl/axis_demux_n.sv
// ---------------------------------------------------------------------------
// axis_demux_n
//
// Purpose:
//   1-to-NUM_M AXI4-Stream demultiplexer with tlast support, optional
//   packet-locked routing, a single registered output stage and discard of
//   beats whose route does not name an existing output channel.
//
// Parameters:
//   DATA_WIDTH   tdata width in bits
//   NUM_M        number of output channels, 2 .. 2**SEL_WIDTH
//   SEL_WIDTH    width of the select input
//   PACKET_MODE  1: route locked from a packet's first beat up to tlast
//                0: route taken from select on every beat
//
// Ports:
//   clk          clock
//   resetn       synchronous, active-low reset
//   s_tvalid     slave stream valid
//   s_tready     slave stream ready (forced low while resetn is low)
//   s_tdata      slave stream data
//   s_tlast      slave stream end of packet
//   select       requested output channel
//   m_tvalid     per-channel valid (at most one bit set)
//   m_tready     per-channel ready
//   m_tdata      per-channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_tlast      per-channel tlast
//   busy         high while a packet is in progress (PACKET_MODE=1 only)
//   drop_count   saturating count of beats discarded on an invalid route
// ---------------------------------------------------------------------------
module axis_demux_n #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_M       = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int PACKET_MODE = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tlast,
  input  logic [SEL_WIDTH-1:0]          select,
  output logic [NUM_M-1:0]              m_tvalid,
  input  logic [NUM_M-1:0]              m_tready,
  output logic [NUM_M*DATA_WIDTH-1:0]   m_tdata,
  output logic [NUM_M-1:0]              m_tlast,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int NUM_SEL = 1 << SEL_WIDTH;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // Output stage
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [SEL_WIDTH-1:0]  r_out_dest;

  // Packet tracking
  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_lock;
  logic                  r_busy;

  logic [15:0]           r_drop_count;

  logic [NUM_SEL-1:0]    w_ready_pad;
  logic                  w_drain;
  logic                  w_accept;
  logic [SEL_WIDTH-1:0]  w_route;
  logic                  w_route_ok;

  // Ready vector widened to every encodable select value so the stage's
  // destination can index it without going out of range; nonexistent
  // channels read as not ready (they are never a stored destination anyway).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_ready_pad
      if (gi < NUM_M) begin : g_real
        assign w_ready_pad[gi] = m_tready[gi];
      end else begin : g_none
        assign w_ready_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // The held beat leaves this cycle when its own channel is ready.
  assign w_drain  = r_out_valid & w_ready_pad[r_out_dest];

  // Accept when the stage is empty or being emptied in the same cycle, so a
  // streaming source sees no bubble while the target keeps up.
  assign s_tready = resetn & (~r_out_valid | w_ready_pad[r_out_dest]);
  assign w_accept = s_tvalid & s_tready;

  // Mid-packet the locked route wins; select only matters on a first beat.
  assign w_route    = ((PACKET_MODE != 0) && (r_state == ST_IN_PKT)) ? r_lock : select;
  assign w_route_ok = (32'(w_route) < 32'(NUM_M));

  // Output stage: load on an accepted beat with a usable route, otherwise
  // empty when drained, otherwise hold everything stable for the sink.
  // A dropped beat leaves the stage to drain or hold as if nothing arrived.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_dest  <= '0;
    end else if (w_accept && w_route_ok) begin
      r_out_valid <= 1'b1;
      r_out_data  <= s_tdata;
      r_out_last  <= s_tlast;
      r_out_dest  <= w_route;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet state machine. An invalid route is locked like any other so the
  // remainder of that packet is discarded rather than split across channels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_lock  <= '0;
      r_busy  <= 1'b0;
    end else if ((PACKET_MODE != 0) && w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!s_tlast) begin
            r_state <= ST_IN_PKT;
            r_lock  <= w_route;
            r_busy  <= 1'b1;
          end
        end
        ST_IN_PKT: begin
          if (s_tlast) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Drop counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drop_count <= '0;
    end else if (w_accept && !w_route_ok && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Every channel sees the same data/last; only the valid bit is steered.
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_out
      assign m_tvalid[gi]                           = r_out_valid & (r_out_dest == SEL_WIDTH'(gi));
      assign m_tdata[gi*DATA_WIDTH +: DATA_WIDTH]   = r_out_data;
      assign m_tlast[gi]                            = r_out_last;
    end
  endgenerate

  assign busy       = r_busy;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_axis_demux_n.sv
// ---------------------------------------------------------------------------
// tb_axis_demux_n
//
// Two demux instances share one stimulus stream:
//   dut A: NUM_M=4, PACKET_MODE=0 (per-beat routing)
//   dut B: NUM_M=3, PACKET_MODE=1 (packet lock, select=3 is an invalid route)
// A transaction-level reference model (a pending-beat queue per instance,
// packet flag, lock and drop tally) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_axis_demux_n;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [1:0]  select;
  logic [3:0]  m_tready;

  logic        a_s_tready;
  logic [3:0]  a_m_tvalid;
  logic [127:0] a_m_tdata;
  logic [3:0]  a_m_tlast;
  logic        a_busy;
  logic [15:0] a_drop_count;

  logic        b_s_tready;
  logic [2:0]  b_m_tvalid;
  logic [95:0] b_m_tdata;
  logic [2:0]  b_m_tlast;
  logic        b_busy;
  logic [15:0] b_drop_count;

  always #5 clk = ~clk;

  axis_demux_n #(.DATA_WIDTH(32), .NUM_M(4), .SEL_WIDTH(2), .PACKET_MODE(0)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(a_s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .select(select),
    .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tdata(a_m_tdata), .m_tlast(a_m_tlast),
    .busy(a_busy), .drop_count(a_drop_count)
  );

  axis_demux_n #(.DATA_WIDTH(32), .NUM_M(3), .SEL_WIDTH(2), .PACKET_MODE(1)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(b_s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .select(select),
    .m_tvalid(b_m_tvalid), .m_tready(m_tready[2:0]), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
    .busy(b_busy), .drop_count(b_drop_count)
  );

  // ------------------------------------------------------------------ model
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  beat_t       pend [2][$];
  int          num_m_of [2] = '{4, 3};
  bit          pmode_of [2] = '{1'b0, 1'b1};
  bit          in_pkt [2];
  int          lock_route [2];
  int          drops [2];
  logic [31:0] last_data [2];
  logic        last_last [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(int k);
    if (resetn !== 1'b1) return 1'b0;
    if (pend[k].size() == 0) return 1'b1;
    return m_tready[pend[k][0].dest];
  endfunction

  function automatic logic [3:0] obs_valid(int k);
    return (k == 0) ? a_m_tvalid : {1'b0, b_m_tvalid};
  endfunction

  function automatic logic [3:0] obs_last(int k);
    return (k == 0) ? a_m_tlast : {1'b0, b_m_tlast};
  endfunction

  function automatic logic [31:0] obs_data(int k, int ch);
    logic [127:0] t;
    t = (k == 0) ? a_m_tdata : {32'h0, b_m_tdata};
    return t[ch*32 +: 32];
  endfunction

  task automatic check_outputs();
    logic [3:0] ev;
    logic [3:0] el;
    for (int k = 0; k < 2; k++) begin
      ev = 4'b0;
      if (pend[k].size() != 0) ev = 4'b1 << pend[k][0].dest;
      el = last_last[k] ? ((k == 0) ? 4'b1111 : 4'b0111) : 4'b0000;
      check_eq($sformatf("s_tready[%0d]", k), (k == 0) ? a_s_tready : b_s_tready, exp_ready(k));
      check_eq($sformatf("m_tvalid[%0d]", k), obs_valid(k), ev);
      check_eq($sformatf("m_tlast[%0d]", k), obs_last(k), el);
      check_eq($sformatf("busy[%0d]", k), (k == 0) ? a_busy : b_busy, pmode_of[k] && in_pkt[k]);
      check_eq($sformatf("drop_count[%0d]", k), (k == 0) ? a_drop_count : b_drop_count, drops[k]);
      for (int ch = 0; ch < num_m_of[k]; ch++)
        check_eq($sformatf("m_tdata[%0d][%0d]", k, ch), obs_data(k, ch), last_data[k]);
    end
  endtask

  // Applied right after a rising edge; inputs still hold the values the
  // DUTs sampled on that edge.
  task automatic model_update();
    bit acc;
    int r;
    for (int k = 0; k < 2; k++) begin
      if (resetn !== 1'b1) begin
        pend[k].delete();
        in_pkt[k] = 1'b0;
        lock_route[k] = 0;
        drops[k] = 0;
        last_data[k] = '0;
        last_last[k] = 1'b0;
      end else begin
        acc = s_tvalid && exp_ready(k);
        if (pend[k].size() != 0 && m_tready[pend[k][0].dest]) void'(pend[k].pop_front());
        if (acc) begin
          r = (pmode_of[k] && in_pkt[k]) ? lock_route[k] : int'(select);
          if (r < num_m_of[k]) begin
            pend[k].push_back('{data: s_tdata, last: s_tlast, dest: 2'(r)});
            last_data[k] = s_tdata;
            last_last[k] = s_tlast;
          end else if (drops[k] < 65535) begin
            drops[k]++;
          end
          if (pmode_of[k]) begin
            if (!in_pkt[k] && !s_tlast) begin
              in_pkt[k] = 1'b1;
              lock_route[k] = r;
            end else if (in_pkt[k] && s_tlast) begin
              in_pkt[k] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  // One clock: check before the edge, advance model after it, return at negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Present one beat and hold it until dut k takes it.
  task automatic send(input int k, input logic [31:0] d, input logic l, input logic [1:0] sel);
    bit ok;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    select   = sel;
    for (int n = 0; n < 64; n++) begin
      ok = exp_ready(k);
      step();
      if (ok) begin
        s_tvalid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", {31'b0, exp_ready(k)}, 32'd1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_pkt[k] = 1'b0; lock_route[k] = 0; drops[k] = 0;
      last_data[k] = '0; last_last[k] = 1'b0;
    end

    // Reset with the source asserting valid
    resetn = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hDEAD_0000; s_tlast = 1'b0;
    select = 2'd0; m_tready = 4'hF;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    check_eq("rst_tready_a", a_s_tready, 0);
    check_eq("rst_tready_b", b_s_tready, 0);
    check_eq("rst_tvalid_a", a_m_tvalid, 0);
    check_eq("rst_tvalid_b", b_m_tvalid, 0);
    check_eq("rst_drop_b", b_drop_count, 0);
    check_eq("rst_busy_b", b_busy, 0);
    for (int i = 0; i < 2; i++) step();

    // Per-beat routing on dut A, one beat per cycle
    resetn = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      s_tdata = 32'hA000_0000 + 32'(i);
      s_tlast = (i == 3);
      if (i > 0) begin
        check_eq("beat_onehot", a_m_tvalid, 32'(4'b1 << (i - 1)));
        check_eq("beat_data", obs_data(0, i - 1), 32'hA000_0000 + 32'(i - 1));
      end
      step();
    end
    s_tvalid = 1'b0;
    check_eq("beat_onehot", a_m_tvalid, 4'b1000);
    step();

    // Packet lock on dut B
    send(1, 32'hB000_0000, 1'b0, 2'd2);
    check_eq("pkt_busy", b_busy, 1);
    send(1, 32'hB000_0001, 1'b0, 2'd1);
    send(1, 32'hB000_0002, 1'b0, 2'd1);
    send(1, 32'hB000_0003, 1'b1, 2'd1);
    check_eq("pkt_tail_valid", b_m_tvalid, 3'b100);
    check_eq("pkt_tail_last", b_m_tlast[2], 1);
    check_eq("pkt_tail_data", obs_data(1, 2), 32'hB000_0003);
    check_eq("pkt_idle", b_busy, 0);
    send(1, 32'hC000_0000, 1'b1, 2'd1);
    check_eq("next_pkt_valid", b_m_tvalid, 3'b010);

    // Back-pressure on channel 1 mid-packet
    send(1, 32'hD000_0000, 1'b0, 2'd1);
    send(1, 32'hD000_0001, 1'b0, 2'd1);
    m_tready = 4'b1101;
    s_tvalid = 1'b1; s_tdata = 32'hD000_0002; s_tlast = 1'b0; select = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_tready", b_s_tready, 0);
      check_eq("bp_hold", obs_data(1, 1), 32'hD000_0001);
      step();
    end
    m_tready = 4'hF;
    send(1, 32'hD000_0002, 1'b0, 2'd1);
    send(1, 32'hD000_0003, 1'b1, 2'd1);
    step();

    // Invalid route on dut B
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    send(1, 32'hE000_0000, 1'b0, 2'd3);
    send(1, 32'hE000_0001, 1'b0, 2'd0);
    send(1, 32'hE000_0002, 1'b1, 2'd0);
    check_eq("drop_three", b_drop_count, 3);
    check_eq("drop_no_valid", b_m_tvalid, 0);
    send(1, 32'hF000_0000, 1'b1, 2'd0);
    check_eq("after_drop_valid", b_m_tvalid, 3'b001);
    check_eq("after_drop_data", obs_data(1, 0), 32'hF000_0000);
    s_tvalid = 1'b1; s_tlast = 1'b0; select = 2'd3;
    for (int i = 0; i < 65540; i++) begin
      s_tdata = 32'(i);
      step();
    end
    s_tvalid = 1'b0;
    check_eq("drop_saturate", b_drop_count, 16'hFFFF);

    // Reset in the middle of a packet
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    send(1, 32'h6000_0000, 1'b0, 2'd1);
    send(1, 32'h6000_0001, 1'b0, 2'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    check_eq("midrst_busy", b_busy, 0);
    check_eq("midrst_valid", b_m_tvalid, 0);
    send(1, 32'h6000_0002, 1'b0, 2'd2);
    check_eq("midrst_reroute", b_m_tvalid, 3'b100);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      resetn   = ($urandom_range(0, 99) != 0);
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(0, 3) == 0);
      select   = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) m_tready[b] = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
